writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..16).
REQ-002 Parameter DW, default 32, SHALL set the data width.
REQ-003 SubClk  in  1  SHALL be the single clock; all state updates on posedge SubClk.
REQ-004 Reset  in  1  SHALL be the synchronous, active-high reset, sampled on posedge SubClk.
REQ-005 MemValid/MemReg/MemData  in  1/5/DW  SHALL be the load-result producer: valid, destination register, value.
REQ-006 MemReady  out  1  SHALL indicate the load result is accepted this cycle.
REQ-007 AluValid/AluReg/AluData  in  1/5/DW  SHALL be the ALU-result producer.
REQ-008 AluReady  out  1  SHALL indicate the ALU result is accepted this cycle.
REQ-009 WbHold  in  1  SHALL stall draining while the register-file write port is borrowed.
REQ-010 RegWrite/WriteRegister/WriteData  out  1/5/DW  SHALL drive the register-file write port.
REQ-011 ReadRegister1/ReadRegister2  in  5/5  SHALL be forwarding lookup addresses.
REQ-012 Fwd1Hit/Fwd1Data, Fwd2Hit/Fwd2Data  out  1/DW each  SHALL return pending queued values for the lookups.

Function
REQ-013 Queue SHALL be a circular FIFO of DEPTH entries {reg, data}, with count 0..DEPTH.
REQ-014 At most one enqueue per cycle; Mem SHALL have fixed priority over Alu.
REQ-015 MemReady = !full; AluReady = !full && !MemValid; both SHALL derive from registered state only (no input-to-ready path other than MemValid).
REQ-016 Accepted result with reg == 0 SHALL be acknowledged but not stored (discarded).
REQ-017 RegWrite = !empty && !WbHold; WriteRegister/WriteData SHALL be the head entry, combinational from FIFO state.
REQ-018 Head SHALL pop at the posedge where RegWrite is 1; the register file writes at that same edge.
REQ-019 Latency: a result accepted at edge N SHALL appear on RegWrite in the cycle following edge N when the queue was empty and WbHold is 0.
REQ-020 Simultaneous enqueue and pop SHALL leave count unchanged; full with pop SHALL still report Ready=0 that cycle (ready is from count, not from the pop).
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-022 FwdNHit SHALL be 1 when any valid entry's reg equals ReadRegisterN and ReadRegisterN != 0; FwdNData SHALL be the youngest matching entry's data.
REQ-023 FwdNData SHALL be 0 when FwdNHit is 0.
REQ-024 Lookup SHALL be combinational and SHALL include the head entry even in its pop cycle.

Reset
REQ-025 On Reset: pointers and count SHALL clear to 0; RegWrite=0, MemReady=AluReady=1, Fwd1Hit=Fwd2Hit=0 in the following cycle.
REQ-026 Reset mid-operation SHALL discard all queued entries; no further RegWrite until a new accept.
REQ-027 Entry storage SHALL need no reset; only valid/count state is reset.
REQ-028 Reset SHALL take precedence over a simultaneous accept or pop.

Structure
REQ-029 Shared package SHALL hold DEPTH and DW defaults, register-index width 5, and the entry field layout.
REQ-030 One sub-module wb_match SHALL implement the youngest-match lookup; instantiated twice (port 1, port 2).
REQ-031 FIFO storage, pointers, and arbitration SHALL reside in writeback_queue itself.

Verification
REQ-032 Reset, then MemValid with reg 5, data 0xAAAA0001 -> RegWrite=1, WriteRegister=5, WriteData=0xAAAA0001 next cycle, for one cycle.
REQ-033 MemValid and AluValid in the same cycle (regs 3, 4) -> MemReady=1, AluReady=0; reg 3 written first, reg 4 after Alu is accepted the next cycle.
REQ-034 WbHold=1, 4 ALU results (regs 1..4) -> count 4, AluReady=0 on the 5th attempt; release WbHold -> 4 writes in order, one per cycle.
REQ-035 Queue reg 7=0x11 then reg 7=0x22 under WbHold, ReadRegister1=7 -> Fwd1Hit=1, Fwd1Data=0x22; ReadRegister2=0 -> Fwd2Hit=0, Fwd2Data=0.
REQ-036 Accept reg 0 -> Ready=1 but no RegWrite; Reset asserted with 3 entries queued -> RegWrite=0 thereafter, Fwd hits cleared.
REQ-037 Run 1000 random accepts and holds vs a reference model -> write sequence matches, no overflow or underflow, pointers wrap correctly.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared sizing and entry layout for the writeback queue
package writeback_queue_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int DW_DEFAULT    = 32;
  localparam int REG_W         = 5;

  // An entry is packed as {reg, data}: data in the low DW bits, reg above it.
  localparam int ENTRY_DATA_LSB = 0;

  function automatic int entry_width(input int dw);
    return REG_W + dw;
  endfunction

  function automatic int entry_reg_lsb(input int dw);
    return ENTRY_DATA_LSB + dw;
  endfunction

endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - youngest-match forwarding lookup over the live queue entries
module wb_match
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic [PW-1:0]       head,
  input  logic [CW-1:0]       count,
  input  logic [DEPTH*REG_W-1:0] regs,
  input  logic [DEPTH*DW-1:0] datas,
  input  logic [REG_W-1:0]    lookup,
  output logic                hit,
  output logic [DW-1:0]       value
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (lookup != '0) &&
          (regs[int'(idx)*REG_W +: REG_W] == lookup)) begin
        hit   = 1'b1;
        value = datas[int'(idx)*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - arbitrated result FIFO feeding the register-file write port
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic             SubClk,
  input  logic             Reset,
  input  logic             MemValid,
  input  logic [REG_W-1:0] MemReg,
  input  logic [DW-1:0]    MemData,
  output logic             MemReady,
  input  logic             AluValid,
  input  logic [REG_W-1:0] AluReg,
  input  logic [DW-1:0]    AluData,
  output logic             AluReady,
  input  logic             WbHold,
  output logic             RegWrite,
  output logic [REG_W-1:0] WriteRegister,
  output logic [DW-1:0]    WriteData,
  input  logic [REG_W-1:0] ReadRegister1,
  input  logic [REG_W-1:0] ReadRegister2,
  output logic             Fwd1Hit,
  output logic [DW-1:0]    Fwd1Data,
  output logic             Fwd2Hit,
  output logic [DW-1:0]    Fwd2Data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_width(DW);
  localparam int RL = entry_reg_lsb(DW);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             mem_acc;
  logic             alu_acc;
  logic             push;
  logic             pop;
  logic [REG_W-1:0] acc_reg;
  logic [DW-1:0]    acc_data;

  logic [DEPTH*REG_W-1:0] regs_flat;
  logic [DEPTH*DW-1:0]    datas_flat;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Readiness comes from the registered count only; a same-cycle pop does not free a slot.
  assign MemReady = !full;
  assign AluReady = !full && !MemValid;

  assign mem_acc = MemValid && !full;
  assign alu_acc = AluValid && !full && !MemValid;

  always_comb begin
    acc_reg  = AluReg;
    acc_data = AluData;
    if (mem_acc) begin
      acc_reg  = MemReg;
      acc_data = MemData;
    end
  end

  // Results targeting r0 are acknowledged but never occupy a slot.
  assign push = (mem_acc || alu_acc) && (acc_reg != '0);
  assign pop  = !empty && !WbHold;

  always_ff @(posedge SubClk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge SubClk) begin
    if (push) mem[tail] <= {acc_reg, acc_data};
  end

  assign RegWrite      = pop;
  assign WriteRegister = mem[head][RL +: REG_W];
  assign WriteData     = mem[head][DW-1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*REG_W +: REG_W] = mem[i][RL +: REG_W];
    assign datas_flat[i*DW +: DW]      = mem[i][DW-1:0];
  end

  wb_match #(.DEPTH(DEPTH), .DW(DW)) u_match1 (
    .head   (head),
    .count  (count),
    .regs   (regs_flat),
    .datas  (datas_flat),
    .lookup (ReadRegister1),
    .hit    (Fwd1Hit),
    .value  (Fwd1Data)
  );

  wb_match #(.DEPTH(DEPTH), .DW(DW)) u_match2 (
    .head   (head),
    .count  (count),
    .regs   (regs_flat),
    .datas  (datas_flat),
    .lookup (ReadRegister2),
    .hit    (Fwd2Hit),
    .value  (Fwd2Data)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed and randomized checks of writeback_queue
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        SubClk = 1'b0;
  logic        Reset;
  logic        MemValid;
  logic [4:0]  MemReg;
  logic [31:0] MemData;
  logic        MemReady;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        AluReady;
  logic        WbHold;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Fwd1Hit;
  logic [31:0] Fwd1Data;
  logic        Fwd2Hit;
  logic [31:0] Fwd2Data;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];

  writeback_queue dut (
    .SubClk        (SubClk),
    .Reset         (Reset),
    .MemValid      (MemValid),
    .MemReg        (MemReg),
    .MemData       (MemData),
    .MemReady      (MemReady),
    .AluValid      (AluValid),
    .AluReg        (AluReg),
    .AluData       (AluData),
    .AluReady      (AluReady),
    .WbHold        (WbHold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .Fwd1Hit       (Fwd1Hit),
    .Fwd1Data      (Fwd1Data),
    .Fwd2Hit       (Fwd2Hit),
    .Fwd2Data      (Fwd2Data)
  );

  always #5 SubClk = ~SubClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SubClk);
    #2;
  endtask

  task automatic idle_inputs();
    MemValid = 1'b0; MemReg = '0; MemData = '0;
    AluValid = 1'b0; AluReg = '0; AluData = '0;
    WbHold = 1'b0; ReadRegister1 = '0; ReadRegister2 = '0;
  endtask

  // Reference: pending writes kept in arrival order; forwarding takes the last match.
  task automatic model_fwd(input logic [4:0] rr, output logic hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (rr != 0)
      foreach (q[i])
        if (q[i].r == rr) begin
          hit = 1'b1;
          val = q[i].d;
        end
  endtask

  initial begin
    logic        e_full, e_wr, e_h1, e_h2;
    logic [31:0] e_d1, e_d2;
    logic        mv, av;
    ent_t        e;

    idle_inputs();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd3;
    #1;
    check("reset_regwrite", RegWrite, 1'b0);
    check("reset_memready", MemReady, 1'b1);
    check("reset_aluready", AluReady, 1'b1);
    check("reset_fwd1hit", Fwd1Hit, 1'b0);
    check("reset_fwd2hit", Fwd2Hit, 1'b0);

    // Single load result, empty queue: one-cycle latency, one write.
    MemValid = 1'b1; MemReg = 5'd5; MemData = 32'hAAAA0001;
    #1 check("single_memready", MemReady, 1'b1);
    tick();
    MemValid = 1'b0;
    #1;
    check("single_regwrite", RegWrite, 1'b1);
    check("single_wreg", WriteRegister, 5'd5);
    check("single_wdata", WriteData, 32'hAAAA0001);
    check("single_fwd1", Fwd1Hit, 1'b1);
    tick();
    #1 check("single_done", RegWrite, 1'b0);

    // Mem beats Alu in the same cycle; Alu goes through the next cycle.
    MemValid = 1'b1; MemReg = 5'd3; MemData = 32'h33;
    AluValid = 1'b1; AluReg = 5'd4; AluData = 32'h44;
    #1;
    check("arb_memready", MemReady, 1'b1);
    check("arb_aluready", AluReady, 1'b0);
    tick();
    MemValid = 1'b0;
    #1;
    check("arb_aluready2", AluReady, 1'b1);
    check("arb_first_wr", RegWrite, 1'b1);
    check("arb_first_reg", WriteRegister, 5'd3);
    tick();
    AluValid = 1'b0;
    #1;
    check("arb_second_wr", RegWrite, 1'b1);
    check("arb_second_reg", WriteRegister, 5'd4);
    check("arb_second_data", WriteData, 32'h44);
    tick();
    #1 check("arb_done", RegWrite, 1'b0);

    // Fill under hold, then drain in order.
    WbHold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      AluValid = 1'b1; AluReg = 5'(i); AluData = 32'h100 + i;
      #1 check("fill_aluready", AluReady, 1'b1);
      tick();
    end
    AluReg = 5'd9; AluData = 32'h999;
    #1;
    check("full_aluready", AluReady, 1'b0);
    check("full_memready", MemReady, 1'b0);
    check("full_hold_nowrite", RegWrite, 1'b0);
    tick();
    AluValid = 1'b1; WbHold = 1'b0;
    #1;
    check("full_pop_ready", AluReady, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) AluValid = 1'b0;
      #1;
      check("drain_wr", RegWrite, 1'b1);
      check("drain_reg", WriteRegister, 5'(i));
      check("drain_data", WriteData, 32'h100 + i);
      tick();
    end
    #1 check("drain_done", RegWrite, 1'b0);

    // Youngest-match forwarding.
    WbHold = 1'b1;
    AluValid = 1'b1; AluReg = 5'd7; AluData = 32'h11;
    tick();
    AluData = 32'h22;
    tick();
    AluValid = 1'b0;
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd0;
    #1;
    check("fwd1_hit", Fwd1Hit, 1'b1);
    check("fwd1_data", Fwd1Data, 32'h22);
    check("fwd2_hit", Fwd2Hit, 1'b0);
    check("fwd2_data", Fwd2Data, 32'h0);

    // Third entry, then reset with a colliding accept: everything is dropped.
    AluValid = 1'b1; AluReg = 5'd8; AluData = 32'h88;
    tick();
    AluValid = 1'b0;
    Reset = 1'b1; MemValid = 1'b1; MemReg = 5'd6; MemData = 32'h66;
    tick();
    Reset = 1'b0; MemValid = 1'b0; WbHold = 1'b0;
    ReadRegister2 = 5'd8;
    #1;
    check("rst_mid_wr", RegWrite, 1'b0);
    check("rst_mid_fwd1", Fwd1Hit, 1'b0);
    check("rst_mid_fwd2", Fwd2Hit, 1'b0);
    tick();
    #1 check("rst_mid_wr2", RegWrite, 1'b0);

    // Register 0 result: acknowledged but discarded.
    MemValid = 1'b1; MemReg = 5'd0; MemData = 32'hDEAD;
    ReadRegister1 = 5'd0;
    #1 check("r0_ready", MemReady, 1'b1);
    tick();
    MemValid = 1'b0;
    #1;
    check("r0_no_write", RegWrite, 1'b0);
    check("r0_no_fwd", Fwd1Hit, 1'b0);
    tick();

    // Randomized run against the queue model.
    idle_inputs();
    q.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      mv = 1'($urandom_range(0, 1));
      av = 1'($urandom_range(0, 1));
      MemValid = mv; MemReg = 5'($urandom_range(0, 7)); MemData = $urandom();
      AluValid = av; AluReg = 5'($urandom_range(0, 7)); AluData = $urandom();
      WbHold = ($urandom_range(0, 2) == 0);
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      #1;
      e_full = (q.size() == DEPTH);
      e_wr   = (q.size() != 0) && !WbHold;
      model_fwd(ReadRegister1, e_h1, e_d1);
      model_fwd(ReadRegister2, e_h2, e_d2);
      check("rnd_memready", MemReady, !e_full);
      check("rnd_aluready", AluReady, !e_full && !mv);
      check("rnd_regwrite", RegWrite, e_wr);
      if (e_wr) begin
        check("rnd_wreg", WriteRegister, q[0].r);
        check("rnd_wdata", WriteData, q[0].d);
      end
      check("rnd_fwd1hit", Fwd1Hit, e_h1);
      check("rnd_fwd1data", Fwd1Data, e_d1);
      check("rnd_fwd2hit", Fwd2Hit, e_h2);
      check("rnd_fwd2data", Fwd2Data, e_d2);
      if (e_wr) void'(q.pop_front());
      if (!e_full && (mv || av)) begin
        e.r = mv ? MemReg : AluReg;
        e.d = mv ? MemData : AluData;
        if (e.r != 0) q.push_back(e);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
